// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: merges hazard, redirect and memory-busy
// conditions into PC/pipeline-register controls, handles HALT drain and counts stalls.
module pipe_stall_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazStall,
    input  logic             imemStall,
    input  logic             dmemStall,
    input  logic             redirect_EX,
    input  logic [15:0]      redirectTgt,
    input  logic             halt_FD,
    output logic             pcWrite,
    output logic             pcRedirect,
    output logic [15:0]      redirectPc,
    output logic             en_FD,
    output logic             en_DX,
    output logic             en_EM,
    output logic             en_MW,
    output logic             flush_FD,
    output logic             bubble_DX,
    output logic             bubble_MW,
    output logic             halted,
    output logic [CNT_W-1:0] stallCnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        IWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      tgt_q, tgt_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_cycle;

    always_comb begin
        pcWrite    = 1'b1;
        pcRedirect = 1'b0;
        redirectPc = redirectTgt;
        en_FD      = 1'b1;
        en_DX      = 1'b1;
        en_EM      = 1'b1;
        en_MW      = 1'b1;
        flush_FD   = 1'b0;
        bubble_DX  = 1'b0;
        bubble_MW  = 1'b0;
        halted     = 1'b0;
        state_d    = state_q;
        tgt_d      = tgt_q;
        drain_d    = drain_q;

        if (rst) begin
            pcWrite   = 1'b0;
            en_FD     = 1'b0;
            en_DX     = 1'b0;
            en_EM     = 1'b0;
            en_MW     = 1'b0;
            flush_FD  = 1'b1;
            bubble_DX = 1'b1;
            bubble_MW = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (dmemStall) begin
                        // Frozen EX re-presents any redirect next cycle, so nothing is latched.
                        pcWrite   = 1'b0;
                        en_FD     = 1'b0;
                        en_DX     = 1'b0;
                        en_EM     = 1'b0;
                        bubble_MW = 1'b1;
                    end else if (redirect_EX) begin
                        flush_FD  = 1'b1;
                        bubble_DX = 1'b1;
                        if (imemStall) begin
                            pcWrite = 1'b0;
                            tgt_d   = redirectTgt;
                            state_d = IWAIT;
                        end else begin
                            pcRedirect = 1'b1;
                        end
                    end else if (hazStall) begin
                        pcWrite   = 1'b0;
                        en_FD     = 1'b0;
                        bubble_DX = 1'b1;
                    end else begin
                        if (imemStall) begin
                            pcWrite  = 1'b0;
                            flush_FD = 1'b1;
                        end
                        if (halt_FD) begin
                            drain_d = 4'd0;
                            state_d = DRAIN;
                        end
                    end
                end

                IWAIT: begin
                    // IF/ID only holds bubbles here, so hazard stalls are irrelevant.
                    pcWrite    = 1'b0;
                    flush_FD   = 1'b1;
                    redirectPc = tgt_q;
                    if (dmemStall) begin
                        en_FD     = 1'b0;
                        en_DX     = 1'b0;
                        en_EM     = 1'b0;
                        bubble_MW = 1'b1;
                    end else if (!imemStall) begin
                        pcWrite    = 1'b1;
                        pcRedirect = 1'b1;
                        state_d    = RUN;
                    end
                end

                DRAIN: begin
                    pcWrite  = 1'b0;
                    flush_FD = 1'b1;
                    if (dmemStall) begin
                        en_FD     = 1'b0;
                        en_DX     = 1'b0;
                        en_EM     = 1'b0;
                        bubble_MW = 1'b1;
                    end else begin
                        if (redirect_EX || hazStall) begin
                            bubble_DX = 1'b1;
                            en_FD     = redirect_EX;
                        end
                        drain_d = drain_q + 4'd1;
                        if (drain_q == DRAIN_LAST) begin
                            state_d = HALTED;
                        end
                    end
                end

                default: begin
                    halted  = 1'b1;
                    pcWrite = 1'b0;
                    en_FD   = 1'b0;
                    en_DX   = 1'b0;
                    en_EM   = 1'b0;
                    en_MW   = 1'b0;
                end
            endcase
        end
    end

    // IWAIT counts as stalled even when imemStall has just dropped.
    assign stall_cycle = (state_q != HALTED) &&
                         (dmemStall || hazStall || imemStall || (state_q == IWAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (stall_cycle && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            tgt_q   <= 16'd0;
            drain_q <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stallCnt  = cnt_q;
    assign dbg_state = state_q;

endmodule
